inst_fetch_resp: RTL and testbench



---
 rtl/inst_fetch_resp_pkg.sv | 23 ++
 rtl/inst_fetch_resp_if.sv | 23 ++
 rtl/inst_fetch_resp.sv | 105 ++++++++++
 tb/tb_inst_fetch_resp.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_resp_pkg.sv
// Shared definitions for the instruction-fetch responder: FSM encoding,
// fetch address width and the word returned for a misaligned fetch.
// Imported by the interface and the top module.
package inst_fetch_resp_pkg;

  localparam int FETCH_AW = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_ADEL = 2'd3
  } fetch_state_e;

  // Returned in place of an instruction when the fetch address is misaligned;
  // the IF stage raises AdEL itself from the returned address.
  localparam logic [FETCH_AW-1:0] ADEL_RDATA = 32'h0;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_resp_if.sv
// SRAM-like instruction bus between the fetch responder and the bus bridge.
// master: responder side (drives inst_req/inst_addr, receives handshakes + data).
// slave : bridge side (drives inst_addr_ok/inst_data_ok/inst_rdata).
interface inst_fetch_resp_if;
  import inst_fetch_resp_pkg::*;

  logic                inst_req;
  logic [FETCH_AW-1:0] inst_addr;
  logic                inst_addr_ok;
  logic                inst_data_ok;
  logic [FETCH_AW-1:0] inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );

endinterface

// File: rtl/inst_fetch_resp.sv
// Purpose     : turns the IF stage fetch address into one instruction-bus read and
//               returns the word + its address with a one-cycle interlayer_ready pulse.
// Latency     : accept T0, inst_req T1, data_ok earliest T2, pulse T3; misaligned pulse at T2.
// Backpressure: inst_req/inst_addr held until inst_addr_ok; one transaction outstanding;
//               IF_skip cancels the in-flight fetch, whose data is drained and dropped.
// Ports       : clk, rst_n (async active-low); IF_skip, IF_mem_addr in from IF;
//               IF_mem_rdata, IF_mem_addr_done, interlayer_ready out to IF;
//               bus (master modport) carries inst_req/inst_addr/inst_addr_ok/
//               inst_data_ok/inst_rdata to the bridge.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                IF_skip,
  input  logic [FETCH_AW-1:0] IF_mem_addr,
  output logic [FETCH_AW-1:0] IF_mem_rdata,
  output logic [FETCH_AW-1:0] IF_mem_addr_done,
  output logic                interlayer_ready,
  inst_fetch_resp_if.master   bus
);

  fetch_state_e        state;
  logic [FETCH_AW-1:0] addr_r;
  logic                cancel;

  // Bus outputs are pure decodes of registers, so nothing from the inputs
  // reaches an output combinationally.
  assign bus.inst_req  = (state == S_REQ);
  assign bus.inst_addr = addr_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      addr_r           <= '0;
      cancel           <= 1'b0;
      IF_mem_rdata     <= '0;
      IF_mem_addr_done <= '0;
      interlayer_ready <= 1'b0;
    end else begin
      interlayer_ready <= 1'b0;

      case (state)
        S_IDLE: begin
          // During the pulse cycle IF still shows the address just completed;
          // it only advances its PC after seeing the pulse, so accepting now
          // would fetch the same word twice.
          if (!IF_skip && !interlayer_ready) begin
            addr_r <= IF_mem_addr;
            cancel <= 1'b0;
            // Same bits that land in addr_r this edge.
            if (ALIGN_CHECK && is_misaligned(IF_mem_addr[1:0])) begin
              state <= S_ADEL;
            end else begin
              state <= S_REQ;
            end
          end
        end

        S_REQ: begin
          // The request stays up even when cancelled: the bridge may already
          // be committed, so the response is drained in WAIT instead.
          if (IF_skip) begin
            cancel <= 1'b1;
          end
          if (bus.inst_addr_ok) begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.inst_data_ok) begin
            // A skip arriving with the data cancels it just like an earlier one.
            if (!cancel && !IF_skip) begin
              IF_mem_rdata     <= bus.inst_rdata;
              IF_mem_addr_done <= addr_r;
              interlayer_ready <= 1'b1;
            end
            cancel <= 1'b0;
            state  <= S_IDLE;
          end else if (IF_skip) begin
            cancel <= 1'b1;
          end
        end

        S_ADEL: begin
          if (!cancel && !IF_skip) begin
            IF_mem_rdata     <= ADEL_RDATA;
            IF_mem_addr_done <= addr_r;
            interlayer_ready <= 1'b1;
          end
          if (IF_skip) begin
            cancel <= 1'b1;
          end
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: two instances (alignment check on / off), the
// bench plays both the IF stage and the bus bridge; completed fetches are
// scoreboarded and matched against interlayer_ready pulses.
module tb_inst_fetch_resp;
  import inst_fetch_resp_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        if_skip;
  logic [1:0][31:0]  if_addr;
  logic [1:0][31:0]  rdata_o;
  logic [1:0][31:0]  done_o;
  logic [1:0]        rdy_o;
  logic [1:0]        aok;
  logic [1:0]        dok;
  logic [1:0][31:0]  brdata;

  inst_fetch_resp_if bus0 ();
  inst_fetch_resp_if bus1 ();

  assign bus0.inst_addr_ok = aok[0];
  assign bus0.inst_data_ok = dok[0];
  assign bus0.inst_rdata   = brdata[0];
  assign bus1.inst_addr_ok = aok[1];
  assign bus1.inst_data_ok = dok[1];
  assign bus1.inst_rdata   = brdata[1];

  inst_fetch_resp #(.ALIGN_CHECK(1'b1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .IF_skip          (if_skip[0]),
    .IF_mem_addr      (if_addr[0]),
    .IF_mem_rdata     (rdata_o[0]),
    .IF_mem_addr_done (done_o[0]),
    .interlayer_ready (rdy_o[0]),
    .bus              (bus0)
  );

  inst_fetch_resp #(.ALIGN_CHECK(1'b0)) dut_na (
    .clk              (clk),
    .rst_n            (rst_n),
    .IF_skip          (if_skip[1]),
    .IF_mem_addr      (if_addr[1]),
    .IF_mem_rdata     (rdata_o[1]),
    .IF_mem_addr_done (done_o[1]),
    .interlayer_ready (rdy_o[1]),
    .bus              (bus1)
  );

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic [31:0] addr;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  logic [1:0][31:0] last_rd;
  logic [1:0][31:0] last_done;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_req(input int d);
    return (d == 0) ? 32'(bus0.inst_req) : 32'(bus1.inst_req);
  endfunction

  function automatic logic [31:0] get_addr(input int d);
    return (d == 0) ? bus0.inst_addr : bus1.inst_addr;
  endfunction

  function automatic logic [31:0] get_rdy(input int d);
    return 32'(rdy_o[d]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int d, input logic [31:0] data, input logic [31:0] a);
    exp_t e;
    e.dut   = d;
    e.rdata = data;
    e.addr  = a;
    sb.push_back(e);
    last_rd[d]   = data;
    last_done[d] = a;
  endtask

  // Every pulse must match the oldest expected completion.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rdy_o[d]) begin
        if (sb.size() == 0) begin
          check($sformatf("unexpected_pulse_d%0d", d), get_rdy(d), 32'h0);
        end else begin
          mon_e = sb.pop_front();
          check("pulse_dut", 32'(d), 32'(mon_e.dut));
          check("pulse_rdata", rdata_o[d], mon_e.rdata);
          check("pulse_addr_done", done_o[d], mon_e.addr);
        end
      end
    end
  end

  // One fetch on instance d. addr_ok comes aok_dly cycles into REQ, data_ok
  // dok_dly cycles into WAIT; skip_c (-1 = none) pulses IF_skip on that cycle
  // counted from the first REQ cycle. Called in a non-pulse IDLE cycle.
  task automatic run_fetch(input int d, input logic [31:0] a, input int aok_dly,
                           input int dok_dly, input logic [31:0] data,
                           input int skip_c, input string tag);
    int done_c;
    bit exp_p;
    done_c = aok_dly + 1 + dok_dly;
    exp_p  = !(skip_c >= 0 && skip_c <= done_c);
    if_addr[d] = a;
    if_skip[d] = 1'b0;
    if (exp_p) expect_pulse(d, data, a);
    step();
    for (int c = 0; c <= done_c; c++) begin
      if_skip[d] = (c == skip_c);
      if (c <= aok_dly) begin
        check({tag, "_req"}, get_req(d), 32'h1);
        check({tag, "_inst_addr"}, get_addr(d), a);
        aok[d] = (c == aok_dly);
        dok[d] = 1'b0;
      end else begin
        aok[d] = 1'b0;
        check({tag, "_req_wait"}, get_req(d), 32'h0);
        dok[d]    = (c == done_c);
        brdata[d] = dok[d] ? data : $urandom();
      end
      step();
    end
    aok[d]     = 1'b0;
    dok[d]     = 1'b0;
    if_skip[d] = 1'b1;
    check({tag, "_pulse"}, get_rdy(d), 32'(exp_p));
    check({tag, "_rdata_out"}, rdata_o[d], last_rd[d]);
    check({tag, "_done_out"}, done_o[d], last_done[d]);
    step();
  endtask

  initial begin
    logic [31:0] ra;
    int          sk;
    if_skip   = 2'b11;
    if_addr   = '0;
    aok       = '0;
    dok       = '0;
    brdata    = '0;
    last_rd   = '0;
    last_done = '0;

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", get_rdy(d), 32'h0);
      check("rst_rdata", rdata_o[d], 32'h0);
      check("rst_done", done_o[d], 32'h0);
      check("rst_req", get_req(d), 32'h0);
      check("rst_inst_addr", get_addr(d), 32'h0);
    end
    rst_n = 1'b1;
    step();

    run_fetch(0, 32'hbfc00000, 0, 0, 32'h3c08bfaf, -1, "basic");
    run_fetch(0, 32'hbfc00004, 3, 2, 32'h24080001, -1, "backpressure");
    run_fetch(0, 32'hbfc00008, 0, 1, 32'hdeadbeef, 1, "cancel_wait");
    run_fetch(0, 32'hbfc00380, 0, 0, 32'h40806000, -1, "handler");
    run_fetch(0, 32'hbfc0000c, 1, 0, 32'h11111111, 1, "skip_with_aok");
    run_fetch(0, 32'hbfc00010, 0, 1, 32'h22222222, 2, "skip_with_dok");
    run_fetch(0, 32'hbfc00014, 1, 1, 32'h33333333, -1, "after_cancel");

    // Misaligned: no bus request, pulse two cycles after acceptance.
    if_addr[0] = 32'hbfc00002;
    if_skip[0] = 1'b0;
    expect_pulse(0, ADEL_RDATA, 32'hbfc00002);
    step();
    check("adel_noreq", get_req(0), 32'h0);
    check("adel_early", get_rdy(0), 32'h0);
    step();
    check("adel_pulse", get_rdy(0), 32'h1);
    check("adel_rdata", rdata_o[0], 32'h0);
    check("adel_done", done_o[0], 32'hbfc00002);
    if_skip[0] = 1'b1;
    step();

    // Misaligned fetch cancelled while in ADEL: no pulse, outputs hold.
    if_addr[0] = 32'hbfc00006;
    if_skip[0] = 1'b0;
    step();
    if_skip[0] = 1'b1;
    check("adel_cancel_noreq", get_req(0), 32'h0);
    step();
    check("adel_cancel_pulse", get_rdy(0), 32'h0);
    check("adel_cancel_rdata", rdata_o[0], last_rd[0]);
    check("adel_cancel_done", done_o[0], last_done[0]);
    step();

    // Without the alignment check a misaligned address goes out on the bus.
    run_fetch(1, 32'hbfc00002, 1, 1, 32'h8fbf0018, -1, "no_align_check");

    // Back-to-back: IF presents the next address in the pulse cycle, the
    // responder must wait one cycle before accepting it.
    if_addr[0] = 32'hbfc00040;
    if_skip[0] = 1'b0;
    expect_pulse(0, 32'h0badf00d, 32'hbfc00040);
    step();
    aok[0] = 1'b1;
    step();
    aok[0]    = 1'b0;
    dok[0]    = 1'b1;
    brdata[0] = 32'h0badf00d;
    step();
    dok[0] = 1'b0;
    check("b2b_first_pulse", get_rdy(0), 32'h1);
    if_addr[0] = 32'hbfc00044;
    expect_pulse(0, 32'h12345678, 32'hbfc00044);
    step();
    check("b2b_gap_req", get_req(0), 32'h0);
    step();
    check("b2b_second_req", get_req(0), 32'h1);
    check("b2b_second_addr", get_addr(0), 32'hbfc00044);
    aok[0] = 1'b1;
    step();
    aok[0]    = 1'b0;
    dok[0]    = 1'b1;
    brdata[0] = 32'h12345678;
    step();
    dok[0]     = 1'b0;
    if_skip[0] = 1'b1;
    check("b2b_second_pulse", get_rdy(0), 32'h1);
    step();

    for (int i = 0; i < 8; i++) begin
      ra = $urandom();
      ra[1:0] = 2'b00;
      sk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_fetch(0, ra, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                $urandom(), sk, "rand");
    end

    // Reset asserted while waiting for data, then a stray data_ok after release.
    if_addr[0] = 32'hbfc00020;
    if_skip[0] = 1'b0;
    step();
    aok[0] = 1'b1;
    step();
    aok[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    last_rd[0]   = '0;
    last_done[0] = '0;
    check("arst_ready", get_rdy(0), 32'h0);
    check("arst_rdata", rdata_o[0], 32'h0);
    check("arst_done", done_o[0], 32'h0);
    check("arst_req", get_req(0), 32'h0);
    check("arst_inst_addr", get_addr(0), 32'h0);
    if_skip[0] = 1'b1;
    step();
    rst_n     = 1'b1;
    dok[0]    = 1'b1;
    aok[0]    = 1'b1;
    brdata[0] = 32'hcafef00d;
    step();
    dok[0] = 1'b0;
    aok[0] = 1'b0;
    check("stray_ready", get_rdy(0), 32'h0);
    check("stray_req", get_req(0), 32'h0);
    check("stray_rdata", rdata_o[0], 32'h0);
    step();
    run_fetch(0, 32'hbfc00024, 0, 0, 32'h00000000, -1, "post_reset");
    run_fetch(0, 32'hbfc00028, 2, 0, 32'h03e00008, -1, "post_reset2");

    repeat (2) step();
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule
